bist_harness: RTL
=================

# bist_harness

On-chip self-test harness for a tiny-tapeout user design. It generates pseudo-random stimulus for a design-under-test (DUT), holds the DUT in reset for a programmable pre-roll, then compacts the DUT response into a signature with a MISR. It compares that signature against a golden value and reports pass/fail. It sits between the pad-level ui/uo buses and the user core, replacing an external bench for silicon bring-up. The block is parametrised in data width, run length, polynomial, seed and reset pre-roll.

## Interface

Parameters:
- WIDTH, 8, width of the stimulus, response and signature buses (minimum 2)
- LEN_W, 8, width of the run-length input
- POLY, 8'h1D, Galois feedback polynomial shared by the LFSR and the MISR (WIDTH bits)
- SEED, 8'h01, LFSR value loaded at start; must be nonzero
- RST_CYC, 2, number of cycles dut_rst is held high before the run (minimum 1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a test; sampled only in IDLE
- abort  in  1  return to IDLE immediately; ignored in IDLE
- len  in  LEN_W  number of RUN cycles; sampled together with start
- golden  in  WIDTH  expected signature; sampled in the DONE cycle
- resp  in  WIDTH  DUT response
- stim  out  WIDTH  DUT stimulus (registered)
- dut_rst  out  1  active-high DUT reset (registered)
- busy  out  1  high in RESET, RUN and DONE
- done  out  1  single-cycle completion pulse
- pass  out  1  signature equals golden; held until the next start
- signature  out  WIDTH  MISR contents; held after completion

## Operation

- FSM states: IDLE, RESET, RUN, DONE.
- IDLE:
  - On start=1, load the LFSR with SEED, clear the MISR and pass, latch len into the down-counter and go to RESET.
  - start is ignored in every other state.
- RESET:
  - dut_rst=1 and stim=0.
  - Stays for RST_CYC cycles, then goes to RUN, or to DONE if the latched len is 0.
- RUN:
  - stim = current LFSR state.
  - At each edge:
    - LFSR <= {lfsr[WIDTH-2:0],1'b0} ^ (lfsr[WIDTH-1] ? POLY : 0).
    - MISR <= {misr[WIDTH-2:0],1'b0} ^ (misr[WIDTH-1] ? POLY : 0) ^ resp.
    - The counter decrements.
  - Leaves for DONE after exactly len RUN cycles.
- DONE:
  - done=1 for one cycle.
  - pass is registered as (MISR == golden) at the edge leaving DONE and held until the next start.
  - Next state is IDLE.
- Outside RUN, stim is 0. dut_rst is high only in RESET.
- abort in RESET, RUN or DONE:
  - Next state is IDLE.
  - dut_rst and stim go to 0.
  - done is not pulsed and pass stays 0.
  - signature keeps its partial value.
- All arithmetic is modulo 2^WIDTH (XOR only). The run-length counter is LEN_W bits with no wrap; the maximum run is 2^LEN_W-1.

## Timing

- Reset values: state IDLE, stim 0, dut_rst 0, busy 0, done 0, pass 0, signature 0, LFSR SEED.
- Reset is asynchronous and overrides everything, including mid-run; release returns the block to IDLE.
- With start sampled at edge E0:
  - dut_rst is high from E0 to E0+RST_CYC.
  - RUN occupies edges E0+RST_CYC through E0+RST_CYC+len.
  - done is high for the cycle after edge E0+RST_CYC+len.
  - pass is valid after edge E0+RST_CYC+len+1.
- busy rises on the edge that samples start and falls on the edge leaving DONE.
- resp is sampled on the same edge that retires the corresponding stim value. The DUT therefore has one full cycle, combinational, from stim to resp.
- Simultaneous start and abort in IDLE: start wins (abort is ignored in IDLE).
- abort in the DONE cycle: done still shows its pulse in that cycle, but pass is not updated.

## Test plan

- WIDTH=8, SEED=01, POLY=1D, resp tied to stim, len=3, golden=04:
  - stim sequence 01,02,04.
  - signature=04, pass=1.
  - done is high for exactly one cycle, 1+2+3 edges after the start edge.
- len=10, resp=0, golden=00:
  - stim sequence 01,02,04,08,10,20,40,80,1D,3A.
  - signature=00, pass=1.
- len=0:
  - dut_rst high for 2 cycles, then done.
  - signature=00, no stim activity.
  - golden=01 gives pass=0.
- abort asserted in the 2nd RUN cycle of a len=5 run:
  - IDLE next cycle, no done pulse, pass=0.
  - busy falls.
  - dut_rst and stim are 0.
- Async rst pulsed mid-RUN between edges:
  - All outputs go to 0 immediately.
  - A following start with len=3 reproduces the first scenario exactly.
- start held high throughout a run:
  - The second test starts only in IDLE, after done.
  - pass from the first run clears on the second start edge.

Source files
------------

// File: rtl/bist_harness_if.sv
// Handshake/bus bundle between a bring-up controller (master) and the BIST harness (slave).
`timescale 1ns/1ps
interface bist_harness_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
);
  logic             start;
  logic             abort;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] golden;
  logic [WIDTH-1:0] resp;
  logic [WIDTH-1:0] stim;
  logic             dut_rst;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] signature;

  modport master (
    output start, abort, len, golden, resp,
    input  stim, dut_rst, busy, done, pass, signature
  );

  modport slave (
    input  start, abort, len, golden, resp,
    output stim, dut_rst, busy, done, pass, signature
  );
endinterface

// File: rtl/bist_harness.sv
// LFSR stimulus + DUT reset pre-roll + MISR compaction; done at start edge + RST_CYC + len.
// No backpressure: start is taken only in IDLE, abort returns to IDLE from any busy state.
`timescale 1ns/1ps
module bist_harness #(
  parameter int               WIDTH   = 8,
  parameter int               LEN_W   = 8,
  parameter logic [WIDTH-1:0] POLY    = 'h1D,
  parameter logic [WIDTH-1:0] SEED    = 'h01,
  parameter int               RST_CYC = 2
) (
  input logic           clk,
  input logic           rst,
  bist_harness_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RESET = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int              RC_W    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYC - 1);

  logic [1:0]       state, state_d;
  logic [WIDTH-1:0] lfsr, lfsr_d;
  logic [WIDTH-1:0] misr, misr_d;
  logic [LEN_W-1:0] cnt, cnt_d;
  logic [RC_W-1:0]  rcnt, rcnt_d;
  logic             pass_q, pass_d;
  logic [WIDTH-1:0] stim_q;
  logic             dut_rst_q;
  logic             done_q;

  function automatic logic [WIDTH-1:0] gstep(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
  endfunction

  always_comb begin
    state_d = state;
    lfsr_d  = lfsr;
    misr_d  = misr;
    cnt_d   = cnt;
    rcnt_d  = rcnt;
    pass_d  = pass_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_d = RESET;
          lfsr_d  = SEED;
          misr_d  = '0;
          pass_d  = 1'b0;
          cnt_d   = bus.len;
          rcnt_d  = '0;
        end
      end
      RESET: begin
        if (rcnt == RC_LAST) begin
          state_d = (cnt == '0) ? DONE : RUN;
        end else begin
          rcnt_d = rcnt + RC_W'(1);
        end
      end
      RUN: begin
        lfsr_d = gstep(lfsr);
        misr_d = gstep(misr) ^ bus.resp;
        cnt_d  = cnt - LEN_W'(1);
        if (cnt == LEN_W'(1)) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        pass_d  = (misr == bus.golden);
      end
    endcase
    // Abort freezes the partial signature and never touches pass.
    if (bus.abort && (state != IDLE)) begin
      state_d = IDLE;
      lfsr_d  = lfsr;
      misr_d  = misr;
      cnt_d   = cnt;
      pass_d  = pass_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= SEED;
      misr      <= '0;
      cnt       <= '0;
      rcnt      <= '0;
      pass_q    <= 1'b0;
      stim_q    <= '0;
      dut_rst_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_d;
      lfsr      <= lfsr_d;
      misr      <= misr_d;
      cnt       <= cnt_d;
      rcnt      <= rcnt_d;
      pass_q    <= pass_d;
      // Outputs are registered off the next state so they line up with it.
      stim_q    <= (state_d == RUN) ? lfsr_d : '0;
      dut_rst_q <= (state_d == RESET);
      done_q    <= (state_d == DONE);
    end
  end

  assign bus.stim      = stim_q;
  assign bus.dut_rst   = dut_rst_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = misr;

endmodule
